// File: rtl/fx3_gpif_pkg.sv
// Shared types and constants for the FX3 GPIF reader model.
// Contents: reader state enum, bus width, default burst/pattern settings,
// and the pattern-increment helper used by the checker.
package fx3_gpif_pkg;

   localparam int unsigned DATA_WIDTH       = 16;
   localparam int unsigned DEF_BURST_WORDS  = 8192;
   localparam logic [DATA_WIDTH-1:0] DEF_PATTERN_MASK = 16'h03FF;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_AVAIL,
      ARM,
      CAPTURE,
      GAP
   } state_t;

   // Next word of the incrementing test pattern, wrapping at the mask.
   function automatic logic [DATA_WIDTH-1:0] next_pattern(
      input logic [DATA_WIDTH-1:0] w,
      input logic [DATA_WIDTH-1:0] mask
   );
      return (w + DATA_WIDTH'(1)) & mask;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the reader statistics.
// Ports: fx3_clock, fx3_nReset (async active-low clear), inc (count enable),
//        count (current value, holds at all-ones).
module sat_counter #(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 fx3_clock,
   input  logic                 fx3_nReset,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   always_ff @(posedge fx3_clock or negedge fx3_nReset) begin
      if (!fx3_nReset) begin
         count <= '0;
      end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
         count <= count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/fx3_gpif_reader.sv
// FPGA-internal FX3 GPIF consumer: waits for dataAvailable, strobes readData
// for one burst, samples dataBus and optionally checks the incrementing
// test pattern while keeping burst / error / overflow statistics.
// Ports: fx3_clock, fx3_nReset, enable, checkPattern, dataAvailable,
//        bufferError, dataBus (in); readData, busy, patternError,
//        burstCount, errorCount, overflowCount, firstErrorWord (out).
module fx3_gpif_reader
   import fx3_gpif_pkg::*;
#(
   parameter int unsigned            BURST_WORDS  = DEF_BURST_WORDS,
   parameter int unsigned            READ_LATENCY = 2,
   parameter int unsigned            GAP_CYCLES   = 4,
   parameter logic [DATA_WIDTH-1:0]  PATTERN_MASK = DEF_PATTERN_MASK,
   parameter int unsigned            CNT_WIDTH    = 16
) (
   input  logic                  fx3_clock,
   input  logic                  fx3_nReset,
   input  logic                  enable,
   input  logic                  checkPattern,
   input  logic                  dataAvailable,
   input  logic                  bufferError,
   input  logic [DATA_WIDTH-1:0] dataBus,
   output logic                  readData,
   output logic                  busy,
   output logic                  patternError,
   output logic [CNT_WIDTH-1:0]  burstCount,
   output logic [CNT_WIDTH-1:0]  errorCount,
   output logic [CNT_WIDTH-1:0]  overflowCount,
   output logic [DATA_WIDTH-1:0] firstErrorWord
);

   localparam int unsigned WCNT_W = $clog2(BURST_WORDS) + 1;
   localparam int unsigned LAT_W  = 2;
   localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);
   localparam int unsigned TAP    = READ_LATENCY - 1;

   localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(BURST_WORDS - 1);
   localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LATENCY - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

   state_t                  state, state_nxt;
   logic                    da_s1, da_s2;
   logic                    be_s1, be_s2, be_d;
   logic [WCNT_W-1:0]       rd_cnt, word_cnt;
   logic [LAT_W-1:0]        lat_cnt;
   logic [GAP_W-1:0]        gap_cnt;
   logic [READ_LATENCY-1:0] vpipe;
   logic                    chk_q;
   logic                    exp_valid;
   logic [DATA_WIDTH-1:0]   exp_word;

   logic arm_entry_c, rd_nxt_c, sample_c, word_last_c, mismatch_c, ovf_rise_c;

   // vpipe[k] mirrors readData k cycles back; the tap marks a valid bus word.
   assign arm_entry_c = (state == WAIT_AVAIL) && (state_nxt == ARM);
   assign sample_c    = vpipe[TAP] && ((state == ARM) || (state == CAPTURE));
   assign word_last_c = sample_c && (word_cnt == LAST_WORD);
   assign mismatch_c  = sample_c && chk_q && exp_valid && (dataBus != exp_word);
   assign ovf_rise_c  = be_s2 && !be_d && (state != IDLE);

   // readData stops after exactly BURST_WORDS high cycles.
   always_comb begin
      rd_nxt_c = readData;
      if (arm_entry_c) begin
         rd_nxt_c = 1'b1;
      end else if (readData && (rd_cnt == LAST_WORD)) begin
         rd_nxt_c = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge fx3_clock or negedge fx3_nReset) begin
      if (!fx3_nReset) state <= IDLE;
      else             state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:       if (enable) state_nxt = WAIT_AVAIL;
         WAIT_AVAIL: begin
            if (!enable)    state_nxt = IDLE;
            else if (da_s2) state_nxt = ARM;
         end
         ARM: begin
            if (word_last_c)              state_nxt = GAP;
            else if (lat_cnt == LAT_LAST) state_nxt = CAPTURE;
         end
         CAPTURE:    if (word_last_c) state_nxt = GAP;
         GAP:        if (gap_cnt == GAP_LAST) state_nxt = enable ? WAIT_AVAIL : IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Synchronisers, strobe generation, burst counters and pattern checker.
   always_ff @(posedge fx3_clock or negedge fx3_nReset) begin
      if (!fx3_nReset) begin
         da_s1          <= 1'b0;
         da_s2          <= 1'b0;
         be_s1          <= 1'b0;
         be_s2          <= 1'b0;
         be_d           <= 1'b0;
         readData       <= 1'b0;
         busy           <= 1'b0;
         vpipe          <= '0;
         rd_cnt         <= '0;
         word_cnt       <= '0;
         lat_cnt        <= '0;
         gap_cnt        <= '0;
         chk_q          <= 1'b0;
         exp_valid      <= 1'b0;
         exp_word       <= '0;
         patternError   <= 1'b0;
         firstErrorWord <= '0;
      end else begin
         da_s1    <= dataAvailable;
         da_s2    <= da_s1;
         be_s1    <= bufferError;
         be_s2    <= be_s1;
         be_d     <= be_s2;
         readData <= rd_nxt_c;
         vpipe    <= (vpipe << 1) | READ_LATENCY'(rd_nxt_c);
         busy     <= (state_nxt == ARM) || (state_nxt == CAPTURE) || (state_nxt == GAP);

         if (arm_entry_c) begin
            rd_cnt   <= '0;
            word_cnt <= '0;
            lat_cnt  <= '0;
            chk_q    <= checkPattern;
         end else begin
            if (readData)       rd_cnt  <= rd_cnt + WCNT_W'(1);
            if (state == ARM)   lat_cnt <= lat_cnt + LAT_W'(1);
            if (sample_c)       word_cnt <= word_cnt + WCNT_W'(1);
         end

         gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;

         // Expected value re-seeds from every sampled word so one glitch
         // costs one error; it persists across bursts until reset.
         if (sample_c && chk_q) begin
            exp_word  <= next_pattern(dataBus, PATTERN_MASK);
            exp_valid <= 1'b1;
            if (mismatch_c && !patternError) begin
               patternError   <= 1'b1;
               firstErrorWord <= dataBus;
            end
         end
      end
   end

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_burst_cnt (
      .fx3_clock  (fx3_clock),
      .fx3_nReset (fx3_nReset),
      .inc        (word_last_c),
      .count      (burstCount)
   );

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_error_cnt (
      .fx3_clock  (fx3_clock),
      .fx3_nReset (fx3_nReset),
      .inc        (mismatch_c),
      .count      (errorCount)
   );

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ovf_cnt (
      .fx3_clock  (fx3_clock),
      .fx3_nReset (fx3_nReset),
      .inc        (ovf_rise_c),
      .count      (overflowCount)
   );

endmodule

// File: tb/tb_fx3_gpif_reader.sv
// Self-checking bench for fx3_gpif_reader: a producer model feeds dataBus
// according to readData, a monitor scores every readData burst length
// against a queue of expected lengths, and the main sequence checks the
// statistics outputs after each scenario.
module tb_fx3_gpif_reader;

   localparam int unsigned BURST = 16;
   localparam int unsigned RL    = 2;
   localparam int unsigned CW    = 4;

   logic          fx3_clock = 1'b0;
   logic          fx3_nReset;
   logic          enable, checkPattern, dataAvailable, bufferError;
   logic [15:0]   dataBus;
   logic          readData, busy, patternError;
   logic [CW-1:0] burstCount, errorCount, overflowCount;
   logic [15:0]   firstErrorWord;

   int total = 0;
   int bad   = 0;

   logic [15:0] data_q[$];
   int          exp_len_q[$];

   fx3_gpif_reader #(
      .BURST_WORDS  (BURST),
      .READ_LATENCY (RL),
      .GAP_CYCLES   (4),
      .PATTERN_MASK (16'h03FF),
      .CNT_WIDTH    (CW)
   ) dut (
      .fx3_clock      (fx3_clock),
      .fx3_nReset     (fx3_nReset),
      .enable         (enable),
      .checkPattern   (checkPattern),
      .dataAvailable  (dataAvailable),
      .bufferError    (bufferError),
      .dataBus        (dataBus),
      .readData       (readData),
      .busy           (busy),
      .patternError   (patternError),
      .burstCount     (burstCount),
      .errorCount     (errorCount),
      .overflowCount  (overflowCount),
      .firstErrorWord (firstErrorWord)
   );

   always #5 fx3_clock = ~fx3_clock;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Producer: word i must be on the bus at the edge RL cycles after the
   // edge that raised readData (plus i).
   logic [3:0] rd_hist = '0;
   always @(posedge fx3_clock) begin
      #1;
      if (!fx3_nReset) begin
         rd_hist = '0;
      end else begin
         rd_hist = {rd_hist[2:0], readData};
         if (rd_hist[RL-1]) begin
            if (data_q.size() > 0) dataBus = data_q.pop_front();
            else                   dataBus = 16'hBEEF;
         end
      end
   end

   // Monitor: score each readData high period against the expected length.
   int   hi_len  = 0;
   logic rd_prev = 1'b0;
   always @(posedge fx3_clock) begin
      #1;
      if (!fx3_nReset) begin
         hi_len  = 0;
         rd_prev = 1'b0;
      end else begin
         if (readData) begin
            hi_len++;
         end else if (rd_prev) begin
            if (exp_len_q.size() == 0) check("rd_unexpected_burst", 32'(hi_len), 32'(0));
            else                       check("rd_len", 32'(hi_len), 32'(exp_len_q.pop_front()));
            hi_len = 0;
         end
         rd_prev = readData;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge fx3_clock);
         #1;
      end
   endtask

   task automatic push_seq(input logic [15:0] start, input int n);
      for (int i = 0; i < n; i++) data_q.push_back(start + 16'(i));
   endtask

   // Raise dataAvailable until readData answers; lat = edges it took.
   task automatic run_burst(input logic chk_en, output int lat);
      checkPattern  = chk_en;
      exp_len_q.push_back(BURST);
      dataAvailable = 1'b1;
      lat = 0;
      while (readData !== 1'b1 && lat < 40) begin
         step(1);
         lat++;
      end
      dataAvailable = 1'b0;
      if (readData !== 1'b1) check("rd_start_timeout", 32'(readData), 32'(1));
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy === 1'b1 && t < 200) begin
         step(1);
         t++;
      end
      if (busy !== 1'b0) check("busy_timeout", 32'(busy), 32'(0));
   endtask

   task automatic pulse_be(input int hi, input int lo);
      bufferError = 1'b1;
      step(hi);
      bufferError = 1'b0;
      step(lo);
   endtask

   task automatic check_zero_state(input string pfx);
      check({pfx, "_readData"},       32'(readData), 32'(0));
      check({pfx, "_busy"},           32'(busy), 32'(0));
      check({pfx, "_burstCount"},     32'(burstCount), 32'(0));
      check({pfx, "_errorCount"},     32'(errorCount), 32'(0));
      check({pfx, "_overflowCount"},  32'(overflowCount), 32'(0));
      check({pfx, "_patternError"},   32'(patternError), 32'(0));
      check({pfx, "_firstErrorWord"}, 32'(firstErrorWord), 32'(0));
   endtask

   initial begin
      int lat;
      int seen;
      fx3_nReset    = 1'b0;
      enable        = 1'b0;
      checkPattern  = 1'b0;
      dataAvailable = 1'b0;
      bufferError   = 1'b0;
      dataBus       = '0;
      step(3);
      check_zero_state("reset");
      fx3_nReset = 1'b1;
      enable     = 1'b1;
      step(3);

      // Basic burst: latency from dataAvailable and strobe length.
      push_seq(16'h0000, BURST);
      run_burst(1'b0, lat);
      check("avail_to_read_cycles", 32'(lat), 32'(3));
      wait_idle();
      check("basic_burstCount", 32'(burstCount), 32'(1));
      check("basic_errorCount", 32'(errorCount), 32'(0));

      // Incrementing pattern across two bursts, wrapping 0x03FF -> 0x0000.
      push_seq(16'h03F0, BURST);
      run_burst(1'b1, lat);
      wait_idle();
      push_seq(16'h0000, BURST);
      run_burst(1'b1, lat);
      wait_idle();
      check("wrap_errorCount",   32'(errorCount), 32'(0));
      check("wrap_patternError", 32'(patternError), 32'(0));
      check("wrap_burstCount",   32'(burstCount), 32'(3));

      // Single glitch: one error, then the sequence resumes from glitch+1.
      push_seq(16'h0010, 5);
      data_q.push_back(16'h1234);
      push_seq(16'h0235, 10);
      run_burst(1'b1, lat);
      wait_idle();
      check("glitch_errorCount",     32'(errorCount), 32'(1));
      check("glitch_patternError",   32'(patternError), 32'(1));
      check("glitch_firstErrorWord", 32'(firstErrorWord), 32'h1234);
      push_seq(16'h023F, BURST);
      run_burst(1'b1, lat);
      wait_idle();
      check("post_glitch_errorCount", 32'(errorCount), 32'(1));
      check("post_glitch_firstWord",  32'(firstErrorWord), 32'h1234);
      check("post_glitch_burstCount", 32'(burstCount), 32'(5));

      // Overflow: two pulses and a long hold count three edges.
      pulse_be(2, 5);
      pulse_be(2, 5);
      pulse_be(50, 6);
      check("ovf_count", 32'(overflowCount), 32'(3));
      enable = 1'b0;
      step(4);
      pulse_be(2, 6);
      check("ovf_idle_ignored", 32'(overflowCount), 32'(3));
      enable = 1'b1;
      step(2);
      for (int i = 0; i < 20; i++) pulse_be(2, 4);
      check("ovf_saturate", 32'(overflowCount), 32'(15));

      // Reset while word 5 of a burst is being sampled.
      push_seq(16'h0050, BURST);
      run_burst(1'b1, lat);
      step(RL + 5);
      #1;
      exp_len_q.delete();
      data_q.delete();
      fx3_nReset = 1'b0;
      #1;
      check_zero_state("midburst_reset");
      step(3);
      fx3_nReset = 1'b1;
      step(3);
      push_seq(16'h0100, BURST);
      run_burst(1'b1, lat);
      check("post_reset_latency", 32'(lat), 32'(3));
      wait_idle();
      check("post_reset_burstCount", 32'(burstCount), 32'(1));
      check("post_reset_errorCount", 32'(errorCount), 32'(0));

      // enable dropped mid-burst: the burst completes, then the reader idles.
      push_seq(16'h0110, BURST);
      run_burst(1'b1, lat);
      step(5);
      enable = 1'b0;
      wait_idle();
      check("en_drop_burstCount", 32'(burstCount), 32'(2));
      check("en_drop_errorCount", 32'(errorCount), 32'(0));
      dataAvailable = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (readData !== 1'b0 || busy !== 1'b0) seen++;
      end
      dataAvailable = 1'b0;
      check("idle_ignores_avail", 32'(seen), 32'(0));
      check("idle_burstCount",    32'(burstCount), 32'(2));

      step(5);
      check("scoreboard_empty", 32'(exp_len_q.size()), 32'(0));
      check("producer_drained", 32'(data_q.size()), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
